ps2_kbd_capture: RTL and testbench

// - Receives PS/2 keyboard frames and tracks the most recently pressed key and a press count.
// - Splits the key code and press count into 4-bit hex nibbles.
// - Each nibble drives one downstream 7-segment hex decoder directly, one digit per nibble.
// - Sits between the board PS/2 pins and the display digits.

---
 rtl/ps2_kbd_capture.sv | 181 ++++++++++++++++++
 tb/tb_ps2_kbd_capture.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_capture.sv
// ps2_kbd_capture: PS/2 keyboard frame receiver with key tracking.
// Receives 11-bit PS/2 frames, decodes make/break sequences, holds the last
// pressed key and a mod-256 press count, and slices both into hex nibbles
// that feed 7-segment decoders directly.
// Optional feature: define PS2_TIMEOUT_EN to enable a watchdog that drops a
// partial frame after TIMEOUT_CYC clk cycles without a ps2_clk falling edge.
module ps2_kbd_capture #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] key_code,
    output logic       key_valid,
    output logic [7:0] press_cnt,
    output logic [3:0] code_lo,
    output logic [3:0] code_hi,
    output logic [3:0] cnt_lo,
    output logic [3:0] cnt_hi,
    output logic       rx_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HELD  = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    // Elaboration-time sanity check on the watchdog length.
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    // Handshake note: frame_ok is a single-cycle valid strobe with no ready;
    // the decode FSM consumes rx_byte in exactly the cycle frame_ok is high.

    logic [2:0] clk_sync;
    logic [1:0] data_sync;
    logic       fall;
    logic       bit_in;
    logic [3:0] bit_idx;
    logic [9:0] shreg;
    logic       frame_good;
    logic       frame_ok;
    logic [7:0] rx_byte;
    logic       drop;

    state_t     state, state_n;
    logic [7:0] key_code_n;
    logic       key_valid_n;
    logic [7:0] press_cnt_n;

    // Synchronise the raw PS/2 pins into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync  <= 3'b000;
            data_sync <= 2'b00;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    assign fall   = clk_sync[2] & ~clk_sync[1];
    assign bit_in = data_sync[1];

    // shreg holds b0 (start) in bit 0 through b9 (parity) in bit 9 once ten
    // bits have been shifted in; bit_in is the stop bit at index 10.
    assign frame_good = ~shreg[0] & bit_in & (^shreg[9:1]);

`ifdef PS2_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] idle_cnt;

    // Count clk cycles since the last ps2_clk falling edge, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (fall) begin
            idle_cnt <= '0;
        end else if (idle_cnt != CNT_W'(TIMEOUT_CYC)) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign drop = (idle_cnt == CNT_W'(TIMEOUT_CYC)) && (bit_idx != 4'd0);
`else
    assign drop = 1'b0;
`endif

    // Shift in frame bits on each falling edge and validate on the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_idx  <= 4'd0;
            shreg    <= 10'd0;
            frame_ok <= 1'b0;
            rx_err   <= 1'b0;
            rx_byte  <= 8'd0;
        end else begin
            frame_ok <= 1'b0;
            rx_err   <= 1'b0;
            if (fall) begin
                if (bit_idx == 4'd10) begin
                    bit_idx <= 4'd0;
                    if (frame_good) begin
                        frame_ok <= 1'b1;
                        rx_byte  <= shreg[8:1];
                    end else begin
                        rx_err <= 1'b1;
                    end
                end else begin
                    shreg   <= {bit_in, shreg[9:1]};
                    bit_idx <= bit_idx + 4'd1;
                end
            end else if (drop) begin
                bit_idx <= 4'd0;
            end
        end
    end

    // Decode FSM state and key-tracking registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            key_code  <= 8'd0;
            key_valid <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            state     <= state_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            press_cnt <= press_cnt_n;
        end
    end

    // Make/break decode; E0 extended prefixes are ignored in every state.
    always_comb begin
        state_n     = state;
        key_code_n  = key_code;
        key_valid_n = key_valid;
        press_cnt_n = press_cnt;
        if (frame_ok && rx_byte != 8'hE0) begin
            case (state)
                ST_IDLE: begin
                    if (rx_byte == 8'hF0) begin
                        state_n = ST_BREAK;
                    end else begin
                        key_code_n  = rx_byte;
                        key_valid_n = 1'b1;
                        press_cnt_n = press_cnt + 8'd1;
                        state_n     = ST_HELD;
                    end
                end
                ST_HELD: begin
                    if (rx_byte == 8'hF0) begin
                        state_n = ST_BREAK;
                    end else if (rx_byte != key_code) begin
                        key_code_n  = rx_byte;
                        press_cnt_n = press_cnt + 8'd1;
                    end
                end
                ST_BREAK: begin
                    if (rx_byte == key_code) begin
                        key_valid_n = 1'b0;
                        state_n     = ST_IDLE;
                    end else begin
                        state_n = key_valid ? ST_HELD : ST_IDLE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign code_lo = key_code[3:0];
    assign code_hi = key_code[7:4];
    assign cnt_lo  = press_cnt[3:0];
    assign cnt_hi  = press_cnt[7:4];

endmodule

// File: tb/tb_ps2_kbd_capture.sv
// tb_ps2_kbd_capture: randomized bench for ps2_kbd_capture with a
// frame-level reference model and a queue-based scoreboard.
// Honours PS2_TIMEOUT_EN in the same way as the design.
module tb_ps2_kbd_capture;

    localparam int TO   = 200;  // watchdog length used for the DUT
    localparam int HALF = 6;    // clk cycles per PS/2 clock half-period
    localparam int GAP  = 16;   // idle clk cycles between frames
    localparam int CHK  = 10;   // clk cycles after the stop edge to check

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_code;
    logic       key_valid;
    logic [7:0] press_cnt;
    logic [3:0] code_lo, code_hi, cnt_lo, cnt_hi;
    logic       rx_err;

    ps2_kbd_capture #(.TIMEOUT_CYC(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .key_code (key_code),
        .key_valid(key_valid),
        .press_cnt(press_cnt),
        .code_lo  (code_lo),
        .code_hi  (code_hi),
        .cnt_lo   (cnt_lo),
        .cnt_hi   (cnt_hi),
        .rx_err   (rx_err)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    // Expected entry: {rx_err, key_valid, key_code, press_cnt}
    logic [17:0] exp_q[$];
    int unsigned due_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;
    int          err_seen = 0;

    // ---------------- reference model ----------------
    // Works on whole frames: collects line bits, judges the frame when all
    // eleven are in, then applies make/break rules to the tracked key.
    bit         m_bits[$];
    logic [7:0] m_key;
    logic       m_valid;
    logic [7:0] m_cnt;
    bit         m_release;  // an F0 was seen and awaits its key byte

    function void push_exp(input logic err);
        exp_q.push_back({err, m_valid, m_key, m_cnt});
        due_q.push_back(cyc + CHK);
    endfunction

    function void model_reset();
        m_bits.delete();
        m_key     = 8'h00;
        m_valid   = 1'b0;
        m_cnt     = 8'h00;
        m_release = 0;
    endfunction

    function void model_byte(input logic [7:0] b);
        if (b == 8'hE0) return;
        if (m_release) begin
            m_release = 0;
            if (b == m_key) m_valid = 1'b0;
        end else if (b == 8'hF0) begin
            m_release = 1;
        end else if (!(m_valid && b == m_key)) begin
            m_key   = b;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 8'd1;
        end
    endfunction

    function void model_bit(input bit b);
        logic [7:0] data;
        int         ones;
        bit         ok;
        m_bits.push_back(b);
        if (m_bits.size() == 11) begin
            ones = 0;
            for (int i = 0; i < 8; i++) begin
                data[i] = m_bits[i+1];
                ones += int'(m_bits[i+1]);
            end
            ones += int'(m_bits[9]);
            ok = (m_bits[0] == 0) && (m_bits[10] == 1) && (ones % 2 == 1);
            if (ok) model_byte(data);
            push_exp(!ok);
            m_bits.delete();
        end
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send_bit(input bit b);
        ps2_data = b;
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b0;
        model_bit(b);
        repeat (HALF) @(posedge clk);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 flipped parity, 2 bad start, 3 bad stop
    task automatic send_frame(input logic [7:0] b, input int kind);
        logic [10:0] f;
        f = {1'b1, ~^b, b, 1'b0};
        if (kind == 1) f[9]  = ~f[9];
        if (kind == 2) f[0]  = 1'b1;
        if (kind == 3) f[10] = 1'b0;
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (due_q.size() > 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        if (due_q.size() > 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain: %0d entries pending, required 0", due_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    task automatic do_reset();
        drain();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        push_exp(1'b0);
    endtask

    // ---------------- monitor / checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                err_seen = 0;
            end else begin
                if (rx_err === 1'b1) err_seen++;
                if (due_q.size() > 0 && cyc >= due_q[0]) begin
                    e = exp_q.pop_front();
                    void'(due_q.pop_front());
                    check("rx_err_count", err_seen, {31'd0, e[17]});
                    check("key_valid", key_valid, {31'd0, e[16]});
                    check("key_code", key_code, {24'd0, e[15:8]});
                    check("press_cnt", press_cnt, {24'd0, e[7:0]});
                    check("code_lo", code_lo, {28'd0, e[11:8]});
                    check("code_hi", code_hi, {28'd0, e[15:12]});
                    check("cnt_lo", cnt_lo, {28'd0, e[3:0]});
                    check("cnt_hi", cnt_hi, {28'd0, e[7:4]});
                    err_seen = 0;
                end
            end
        end
    end

    // Global time limit so the run always terminates.
    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] b;
        int         kind;
        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        rst = 1'b0;
        push_exp(1'b0);

        // Press, typematic repeats, release, extended release.
        send_frame(8'h1C, 0);
        repeat (3) send_frame(8'h1C, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);

        // Rejected frames of each flavour.
        send_frame(8'h32, 1);
        send_frame(8'h15, 2);
        send_frame(8'h24, 3);

        // Randomized mix of codes, prefixes and occasional bad frames.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: b = 8'h1C;
                1: b = 8'h32;
                2: b = 8'h15;
                3: b = 8'hF0;
                4: b = 8'hE0;
                default: b = 8'($urandom_range(0, 255));
            endcase
            kind = ($urandom_range(0, 9) < 8) ? 0 : int'($urandom_range(1, 3));
            send_frame(b, kind);
        end

        // 256 distinct presses from reset wrap the count to zero.
        do_reset();
        for (int i = 0; i < 256; i++) send_frame((i % 2 == 0) ? 8'h1C : 8'h32, 0);

        // Four more alternating presses.
        for (int i = 0; i < 4; i++) send_frame((i % 2 == 0) ? 8'h1C : 8'h32, 0);

        // Partial frame followed by a long idle, then a clean frame.
        do_reset();
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        repeat (TO + 2) @(posedge clk);
`ifdef PS2_TIMEOUT_EN
        m_bits.delete();
`endif
        send_frame(8'h32, 0);

        // Reset in the middle of a frame, then a clean frame.
        do_reset();
        for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)));
        ps2_data = 1'b1;
        repeat (GAP) @(posedge clk);
        do_reset();
        send_frame(8'h15, 0);

        drain();
        repeat (4) @(negedge clk);
        check("stray_rx_err", err_seen, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
